// File: rtl/wb_write_arbiter_pkg.sv
// Shared types for the writeback arbiter and its load-return FIFO.
// A FIFO entry is one pending register-file write.
package wb_write_arbiter_pkg;

  typedef logic [3:0]  reg_addr_t;
  typedef logic [31:0] word_t;

  typedef struct packed {
    reg_addr_t rd;
    word_t     val;
  } wb_req_t;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } arb_state_e;

endpackage

// File: rtl/wb_load_fifo.sv
// Load-return FIFO with per-entry live bits. A live bit drops when a younger
// pipeline write to the same register supersedes the buffered load.
module wb_load_fifo
  import wb_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      pushEn,
  input  wb_req_t   pushReq,
  input  logic      popEn,
  input  logic      killEn,
  input  reg_addr_t killRd,
  input  reg_addr_t qRn,
  input  reg_addr_t qRm,
  output logic      empty,
  output logic      full,
  output logic      headLive,
  output wb_req_t   headReq,
  output logic      pendRn,
  output logic      pendRm
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_req_t          mem [DEPTH];
  logic [DEPTH-1:0] live;
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic [CW-1:0]    count;
  logic             doPush;
  logic             doPop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign doPush   = pushEn && !full;
  assign doPop    = popEn && !empty;
  assign headReq  = mem[rdPtr];
  assign headLive = !empty && live[rdPtr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (doPush) begin
      mem[wrPtr] <= pushReq;
    end
  end

  // A push into a slot wins over a kill: the incoming load is younger than the pipe write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (doPush && wrPtr == PW'(i)) begin
          live[i] <= 1'b1;
        end else if (doPop && rdPtr == PW'(i)) begin
          live[i] <= 1'b0;
        end else if (killEn && mem[i].rd == killRd) begin
          live[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PW'(1);
      if (doPop)  rdPtr <= rdPtr + PW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    pendRn = 1'b0;
    pendRm = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      pendRn = pendRn | (live[i] && mem[i].rd == qRn);
      pendRm = pendRm | (live[i] && mem[i].rd == qRm);
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Drives the register file's single write port from the pipeline (priority)
// and the buffered load returns, and requests a stall when loads starve.
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_valid,
  input  logic [3:0]  pipe_rd,
  input  logic [31:0] pipe_val,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [3:0]  ld_rd,
  input  logic [31:0] ld_val,
  input  logic [3:0]  q_rn,
  input  logic [3:0]  q_rm,
  output logic        pend_rn,
  output logic        pend_rm,
  output logic        stall_req,
  output logic        WB_EN,
  output logic [3:0]  RdAddress,
  output logic [31:0] WBVal,
  output arb_state_e  arbState
);

  localparam int SW = $clog2(STARVE_MAX) + 1;

  logic          fifoEmpty;
  logic          fifoFull;
  logic          headLive;
  logic          pushEn;
  logic          popEn;
  logic          doWrite;
  wb_req_t       ldReq;
  wb_req_t       headReq;
  wb_req_t       selReq;
  logic [SW-1:0] starveCnt;
  logic [SW-1:0] starveNext;
  arb_state_e    state;
  arb_state_e    stateNext;

  assign ld_ready = !fifoFull;
  assign pushEn   = ld_valid && ld_ready;
  assign popEn    = !pipe_valid && !fifoEmpty;
  assign ldReq    = '{rd: ld_rd, val: ld_val};

  wb_load_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .pushEn  (pushEn),
    .pushReq (ldReq),
    .popEn   (popEn),
    .killEn  (pipe_valid),
    .killRd  (pipe_rd),
    .qRn     (q_rn),
    .qRm     (q_rm),
    .empty   (fifoEmpty),
    .full    (fifoFull),
    .headLive(headLive),
    .headReq (headReq),
    .pendRn  (pend_rn),
    .pendRm  (pend_rm)
  );

  // A dead head is popped with no write; the write port stays idle that cycle.
  always_comb begin
    doWrite = 1'b0;
    selReq  = headReq;
    if (pipe_valid) begin
      doWrite = 1'b1;
      selReq  = '{rd: pipe_rd, val: pipe_val};
    end else if (headLive) begin
      doWrite = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      WB_EN     <= 1'b0;
      RdAddress <= '0;
      WBVal     <= '0;
    end else begin
      WB_EN <= doWrite;
      if (doWrite) begin
        RdAddress <= selReq.rd;
        WBVal     <= selReq.val;
      end
    end
  end

  // Saturating count of cycles a live head has been held back by the pipeline.
  always_comb begin
    starveNext = starveCnt;
    if (fifoEmpty || popEn) begin
      starveNext = '0;
    end else if (headLive && starveCnt != SW'(STARVE_MAX - 1)) begin
      starveNext = starveCnt + SW'(1);
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:  if (starveNext == SW'(STARVE_MAX - 1)) stateNext = STALL;
      STALL: if (fifoEmpty) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starveCnt <= '0;
      state     <= IDLE;
    end else begin
      starveCnt <= starveNext;
      state     <= stateNext;
    end
  end

  assign stall_req = (state == STALL);
  assign arbState  = state;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: directed scenarios plus a random run,
// all compared against a queue-based model of the writeback rules.
module tb_wb_write_arbiter;
  import wb_write_arbiter_pkg::*;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid;
  logic [3:0]  pipe_rd;
  logic [31:0] pipe_val;
  logic        ld_valid;
  logic        ld_ready;
  logic [3:0]  ld_rd;
  logic [31:0] ld_val;
  logic [3:0]  q_rn;
  logic [3:0]  q_rm;
  logic        pend_rn;
  logic        pend_rm;
  logic        stall_req;
  logic        WB_EN;
  logic [3:0]  RdAddress;
  logic [31:0] WBVal;
  arb_state_e  arbState;

  always #5 clk = ~clk;

  wb_write_arbiter #(
    .DEPTH(DEPTH),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_val(pipe_val),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_val(ld_val),
    .q_rn(q_rn), .q_rm(q_rm), .pend_rn(pend_rn), .pend_rm(pend_rm),
    .stall_req(stall_req), .WB_EN(WB_EN), .RdAddress(RdAddress), .WBVal(WBVal),
    .arbState(arbState)
  );

  // Reference model: buffered loads in arrival order, each with a still-wanted flag.
  typedef struct {
    logic [3:0]  rd;
    logic [31:0] val;
    bit          live;
  } ent_t;

  ent_t        mq[$];
  int          mWait;
  bit          mStall;
  bit          mWbEn;
  logic [3:0]  mRd;
  logic [31:0] mVal;
  logic [35:0] exp_q[$];
  int          nCmp;
  int          nFail;

  function automatic bit m_pend(logic [3:0] q);
    for (int i = 0; i < mq.size(); i++) if (mq[i].live && mq[i].rd == q) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [2:0] m_pre();
    return {mq.size() < DEPTH, m_pend(q_rn), m_pend(q_rm)};
  endfunction

  function automatic logic [2:0] d_pre();
    return {ld_ready, pend_rn, pend_rm};
  endfunction

  function automatic logic [37:0] m_post();
    return {mWbEn, mWbEn ? mRd : 4'h0, mWbEn ? mVal : 32'h0, mStall};
  endfunction

  function automatic logic [37:0] d_post();
    return {WB_EN, WB_EN ? RdAddress : 4'h0, WB_EN ? WBVal : 32'h0, stall_req};
  endfunction

  task automatic model_reset();
    mq.delete();
    mWait  = 0;
    mStall = 1'b0;
    mWbEn  = 1'b0;
    mRd    = '0;
    mVal   = '0;
  endtask

  task automatic model_edge();
    bit   wasEmpty, headLv, popped, wr, canPush;
    ent_t e;
    wasEmpty = (mq.size() == 0);
    headLv   = !wasEmpty && mq[0].live;
    canPush  = ld_valid && (mq.size() < DEPTH);
    popped   = 1'b0;
    wr       = 1'b0;
    if (pipe_valid) begin
      wr   = 1'b1;
      mRd  = pipe_rd;
      mVal = pipe_val;
      for (int i = 0; i < mq.size(); i++) if (mq[i].rd == pipe_rd) mq[i].live = 1'b0;
    end else if (!wasEmpty) begin
      e      = mq.pop_front();
      popped = 1'b1;
      if (e.live) begin
        wr   = 1'b1;
        mRd  = e.rd;
        mVal = e.val;
      end
    end
    mWbEn = wr;
    if (canPush) mq.push_back('{rd: ld_rd, val: ld_val, live: 1'b1});
    if (wasEmpty || popped) begin
      mWait = 0;
    end else if (headLv && mWait < STARVE_MAX - 1) begin
      mWait++;
      if (mWait == STARVE_MAX - 1) mStall = 1'b1;
    end
    if (mStall && wasEmpty) mStall = 1'b0;
  endtask

  task automatic drive(input logic pv, input logic [3:0] prd, input logic [31:0] pval,
                       input logic lv, input logic [3:0] lrd, input logic [31:0] lval,
                       input logic [3:0] qn, input logic [3:0] qm);
    pipe_valid = pv;
    pipe_rd    = prd;
    pipe_val   = pval;
    ld_valid   = lv;
    ld_rd      = lrd;
    ld_val     = lval;
    q_rn       = qn;
    q_rm       = qm;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    logic [38:0] got;
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    got = {WB_EN, RdAddress, WBVal, ld_ready, stall_req};
    nCmp++;
    if (got !== {1'b0, 4'h0, 32'h0, 1'b1, 1'b0}) begin
      nFail++; $display("FAIL reset_hold got=%h exp=%h", got, {1'b0, 4'h0, 32'h0, 1'b1, 1'b0});
    end
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      tick();
      got = {WB_EN, RdAddress, WBVal, ld_ready, stall_req};
      nCmp++;
      if (got !== {1'b0, 4'h0, 32'h0, 1'b1, 1'b0}) begin
        nFail++; $display("FAIL reset_idle c=%0d got=%h exp=%h", c, got, {1'b0, 4'h0, 32'h0, 1'b1, 1'b0});
      end
    end
  endtask

  task automatic test_pipe_write();
    drive(1, 4'd3, 32'hAA, 0, 0, 0, 0, 0);
    tick();
    nCmp++;
    if ({WB_EN, RdAddress, WBVal} !== {1'b1, 4'd3, 32'hAA}) begin
      nFail++; $display("FAIL pipe_write got=%h exp=%h", {WB_EN, RdAddress, WBVal}, {1'b1, 4'd3, 32'hAA});
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    nCmp++;
    if (WB_EN !== 1'b0) begin
      nFail++; $display("FAIL pipe_write_off got=%b exp=0", WB_EN);
    end
  endtask

  task automatic test_load_order();
    logic [3:0]  rds  [3];
    logic [31:0] vals [3];
    logic [35:0] e;
    rds[0] = 4'd1; rds[1] = 4'd2; rds[2] = 4'd4;
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h44;
    for (int c = 0; c < 6; c++) begin
      if (c < 3) begin
        drive(0, 0, 0, 1, rds[c], vals[c], 4'd2, 4'($urandom_range(0, 15)));
        exp_q.push_back({rds[c], vals[c]});
      end else begin
        drive(0, 0, 0, 0, 0, 0, 4'd2, 4'd4);
      end
      nCmp++;
      if (d_pre() !== m_pre()) begin
        nFail++; $display("FAIL load_order_pre c=%0d got=%b exp=%b", c, d_pre(), m_pre());
      end
      tick();
      nCmp++;
      if (d_post() !== m_post()) begin
        nFail++; $display("FAIL load_order_post c=%0d got=%h exp=%h", c, d_post(), m_post());
      end
      if (WB_EN === 1'b1) begin
        nCmp++;
        if (exp_q.size() == 0) begin
          nFail++; $display("FAIL load_order_extra got=%h exp=none", {RdAddress, WBVal});
        end else begin
          e = exp_q.pop_front();
          if ({RdAddress, WBVal} !== e) begin
            nFail++; $display("FAIL load_order_sb got=%h exp=%h", {RdAddress, WBVal}, e);
          end
        end
      end
    end
    nCmp++;
    if (exp_q.size() != 0) begin
      nFail++; $display("FAIL load_order_missing got=%0d left exp=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_fill_stall();
    int         riseAt = -1;
    int         fallAt = -1;
    logic [3:0] lrd;
    for (int c = 0; c < 16; c++) begin
      lrd = (c < 4) ? 4'(8 + c) : 4'd12;
      drive(!mStall, 4'($urandom_range(0, 7)), $urandom, c < 6, lrd, $urandom,
            4'(8 + (c % 4)), 4'($urandom_range(0, 15)));
      nCmp++;
      if (d_pre() !== m_pre()) begin
        nFail++; $display("FAIL fill_pre c=%0d got=%b exp=%b", c, d_pre(), m_pre());
      end
      if (c == 4) begin
        nCmp++;
        if (ld_ready !== 1'b0) begin
          nFail++; $display("FAIL fill_full_ready got=%b exp=0", ld_ready);
        end
      end
      tick();
      nCmp++;
      if (d_post() !== m_post()) begin
        nFail++; $display("FAIL fill_post c=%0d got=%h exp=%h", c, d_post(), m_post());
      end
      if (riseAt < 0 && stall_req === 1'b1) riseAt = c + 1;
      if (riseAt >= 0 && fallAt < 0 && stall_req === 1'b0) fallAt = c + 1;
    end
    nCmp++;
    if (riseAt != STARVE_MAX) begin
      nFail++; $display("FAIL stall_rise got=%0d exp=%0d", riseAt, STARVE_MAX);
    end
    nCmp++;
    if (fallAt != STARVE_MAX + DEPTH + 1) begin
      nFail++; $display("FAIL stall_fall got=%0d exp=%0d", fallAt, STARVE_MAX + DEPTH + 1);
    end
  endtask

  task automatic test_waw_kill();
    int          wr5 = 0;
    logic [31:0] last5 = '0;
    for (int c = 0; c < 4; c++) begin
      case (c)
        0:       drive(0, 0, 0, 1, 4'd5, 32'h55, 4'd5, 4'd0);
        1:       drive(1, 4'd5, 32'h99, 0, 0, 0, 4'd5, 4'd0);
        default: drive(0, 0, 0, 0, 0, 0, 4'd5, 4'd0);
      endcase
      nCmp++;
      if (d_pre() !== m_pre()) begin
        nFail++; $display("FAIL waw_pre c=%0d got=%b exp=%b", c, d_pre(), m_pre());
      end
      if (c >= 2) begin
        nCmp++;
        if (pend_rn !== 1'b0) begin
          nFail++; $display("FAIL waw_pend_after_kill c=%0d got=%b exp=0", c, pend_rn);
        end
      end
      tick();
      nCmp++;
      if (d_post() !== m_post()) begin
        nFail++; $display("FAIL waw_post c=%0d got=%h exp=%h", c, d_post(), m_post());
      end
      if (WB_EN === 1'b1 && RdAddress === 4'd5) begin
        wr5++;
        last5 = WBVal;
      end
    end
    nCmp++;
    if (wr5 != 1 || last5 !== 32'h99) begin
      nFail++; $display("FAIL waw_writes got=%0d/%h exp=1/00000099", wr5, last5);
    end
  endtask

  task automatic test_same_cycle();
    drive(1, 4'd6, 32'h66, 1, 4'd6, 32'h77, 4'd6, 4'd6);
    tick();
    nCmp++;
    if ({WB_EN, RdAddress, WBVal} !== {1'b1, 4'd6, 32'h66}) begin
      nFail++; $display("FAIL same_first got=%h exp=%h", {WB_EN, RdAddress, WBVal}, {1'b1, 4'd6, 32'h66});
    end
    drive(0, 0, 0, 0, 0, 0, 4'd6, 4'd6);
    nCmp++;
    if (pend_rn !== 1'b1) begin
      nFail++; $display("FAIL same_pend got=%b exp=1", pend_rn);
    end
    tick();
    nCmp++;
    if ({WB_EN, RdAddress, WBVal} !== {1'b1, 4'd6, 32'h77}) begin
      nFail++; $display("FAIL same_second got=%h exp=%h", {WB_EN, RdAddress, WBVal}, {1'b1, 4'd6, 32'h77});
    end
    tick();
    nCmp++;
    if (d_post() !== m_post()) begin
      nFail++; $display("FAIL same_after got=%h exp=%h", d_post(), m_post());
    end
  endtask

  task automatic test_reset_mid_drain();
    int          writes = 0;
    logic [40:0] got;
    for (int c = 0; c < 4; c++) begin
      drive(1, 4'($urandom_range(0, 7)), $urandom, 1, 4'(9 + c), $urandom, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 4'd10, 4'd11);
    tick();
    nCmp++;
    if (d_pre() !== m_pre()) begin
      nFail++; $display("FAIL middrain_pre got=%b exp=%b", d_pre(), m_pre());
    end
    rst = 1'b0;
    model_reset();
    #1;
    got = {WB_EN, RdAddress, WBVal, stall_req, ld_ready, pend_rn, pend_rm};
    nCmp++;
    if (got !== {1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      nFail++; $display("FAIL middrain_async got=%h exp=%h", got, {1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0});
    end
    @(posedge clk);
    #1 rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      drive(0, 0, 0, 0, 0, 0, 4'd10, 4'd11);
      tick();
      nCmp++;
      if (d_post() !== m_post() || ld_ready !== 1'b1) begin
        nFail++; $display("FAIL middrain_after c=%0d got=%h/%b exp=%h/1", c, d_post(), ld_ready, m_post());
      end
      if (WB_EN === 1'b1) writes++;
    end
    nCmp++;
    if (writes != 0) begin
      nFail++; $display("FAIL middrain_writes got=%0d exp=0", writes);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(!mStall && ($urandom_range(0, 99) < 45), 4'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 99) < 40, 4'($urandom_range(0, 7)), $urandom,
            4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)));
      nCmp++;
      if (d_pre() !== m_pre()) begin
        nFail++; $display("FAIL random_pre c=%0d got=%b exp=%b", c, d_pre(), m_pre());
      end
      tick();
      nCmp++;
      if (d_post() !== m_post()) begin
        nFail++; $display("FAIL random_post c=%0d got=%h exp=%h", c, d_post(), m_post());
      end
    end
  endtask

  initial begin
    nCmp  = 0;
    nFail = 0;
    rst   = 1'b0;
    model_reset();
    test_reset();
    test_pipe_write();
    test_load_order();
    test_fill_stall();
    test_waw_kill();
    test_same_cycle();
    test_reset_mid_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
Writeback-side producer for the 16x32 register file's single write port (WB_EN, RdAddress, WBVal). It merges two sources: the in-order pipeline result stream, which is never stalled by this block and has priority, and a slow data-memory load-return stream, which is buffered in a small FIFO. It also exposes a pending-write scoreboard lookup so the decode stage can detect hazards against buffered loads, and raises a stall request when loads starve.

Parameters:
DEPTH, 4, load-return FIFO entries (power of 2, >=2)
STARVE_MAX, 8, cycles the FIFO head may wait before stall_req asserts

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
pipe_valid  in  1  pipeline writeback request this cycle
pipe_rd  in  4  pipeline destination register
pipe_val  in  32  pipeline result
ld_valid  in  1  load-return valid
ld_ready  out  1  FIFO can accept (= not full)
ld_rd  in  4  load destination register
ld_val  in  32  load data
q_rn  in  4  decode hazard query address A
q_rm  in  4  decode hazard query address B
pend_rn  out  1  a live FIFO entry targets q_rn
pend_rm  out  1  a live FIFO entry targets q_rm
stall_req  out  1  pipeline must hold off pipe_valid
WB_EN  out  1  register-file write enable
RdAddress  out  4  register-file write address
WBVal  out  32  register-file write data

Behaviour:
- Reset (rst=0, asynchronous): WB_EN=0, RdAddress=0, WBVal=0, FIFO empty (all entry-live bits 0, pointers 0, count 0), starve counter 0, stall_req=0. ld_ready reads 1 while in reset.
- Outputs WB_EN/RdAddress/WBVal are registered on posedge clk, so they carry 1-cycle latency from the selected source. The register file samples them on negedge, mid-cycle.
- Per-cycle selection:
  - pipe_valid=1: write pipe_rd/pipe_val.
  - Otherwise, if the FIFO head is live: write the head and pop it.
  - Otherwise, if the FIFO head is dead: pop it silently with no write; WB_EN=0.
  - Otherwise: WB_EN=0.
- FIFO push: when ld_valid && ld_ready, the entry is stored live. Push and pop in the same cycle are allowed; count stays unchanged. When full, ld_ready=0 and ld_valid is ignored (no overwrite).
- WAW kill: when pipe_valid=1, every live FIFO entry with rd==pipe_rd is marked dead in the same edge, because the younger pipeline write supersedes it. A load pushed in that same cycle with ld_rd==pipe_rd is stored live, because it is younger.
- Scoreboard lookup is combinational: pend_rn = OR over live entries of (rd==q_rn); pend_rm likewise. Dead entries never hit.
- Starvation handling:
  - The counter increments each cycle the head is live and not popped.
  - The counter clears on any pop or when the FIFO is empty.
  - stall_req is registered: it sets when the counter reaches STARVE_MAX-1 and clears the cycle after the FIFO becomes empty.
  - Pipeline contract: while stall_req=1, pipe_valid=0. If pipe_valid is violated, it still wins and is written.
- Pointers wrap modulo DEPTH. count has width clog2(DEPTH)+1.
- All FIFO storage and the starvation state are cleared by reset, including reset asserted mid-drain.

Decomposition:
- Shared package: typedef reg_addr_t (logic [3:0]), word_t (logic [31:0]), and struct wb_req_t {rd, val}.
- One natural sub-module: wb_load_fifo. It holds the storage, live bits, pointers and count, and implements push, pop, kill-by-address and the two lookup ports.
- wb_write_arbiter holds the selection mux, output registers and starvation FSM. The FSM has two states, IDLE and STALL.

Test Plan:
- Reset release, no traffic: WB_EN=0, RdAddress=0, WBVal=0, ld_ready=1, stall_req=0 for 5 cycles.
- Pipe write r3=0x0000_00AA at cycle n: WB_EN=1, RdAddress=3, WBVal=0xAA at cycle n+1; WB_EN=0 at n+2.
- Push loads r1=0x11, r2=0x22, r4=0x44 while idle: three writes in FIFO order on consecutive cycles. pend for q_rn=2 is 1 until r2 pops.
- Fill DEPTH=4 loads while pipe_valid=1 every cycle: ld_ready=0 after 4 pushes. stall_req=1 exactly STARVE_MAX cycles after the first push. Drop pipe_valid and the FIFO drains in 4 cycles; stall_req=0 the cycle after empty.
- WAW kill: queue load r5=0x55, then pipe write r5=0x99 the next cycle. Only the r5=0x99 write occurs, and pend_rn(q=5)=0 after the kill edge.
- Same cycle: pipe r6=0x66 plus a new load push r6=0x77. Write 0x66 first, then 0x77 on the following idle cycle.
- Assert rst mid-drain with 3 entries queued: all outputs zero immediately (asynchronously). After release there are no writes and ld_ready=1.
